// File: rtl/sm_addsub_serial.sv
// Bit-serial sign-magnitude adder/subtractor: true form -> two's complement -> serial add -> true form.
// Optional macro SM_ADDSUB_TWOBIT_EN: CALC retires two sum bits per cycle instead of one.
module sm_addsub_serial #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

`ifdef SM_ADDSUB_TWOBIT_EN
  localparam int unsigned STEP = 2;
`else
  localparam int unsigned STEP = 1;
`endif
  // ceil((WIDTH+1)/STEP) cycles; the shift registers are padded to a whole number of steps
  localparam int unsigned NCYC = (WIDTH + STEP) / STEP;
  localparam int unsigned SW   = NCYC * STEP;
  localparam int unsigned CW   = $clog2(NCYC);

  typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt_q;
  logic [SW-1:0]   opa_q, opb_q, sum_q;
  logic            carry_q, carry_c;
  logic [STEP-1:0] sbits_c;
  logic [SW-1:0]   mag_c;
  logic            accept_c, last_c;

  // Sign-magnitude to sign-extended two's complement; -0 maps to 0 naturally.
  function automatic logic [SW-1:0] to_tc(input logic sgn, input logic [WIDTH-2:0] mag);
    logic [SW-1:0] ext;
    ext = SW'(mag);
    return sgn ? -ext : ext;
  endfunction

  assign accept_c = in_valid && (state == IDLE);
  assign last_c   = (cnt_q == CW'(NCYC - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (in_valid) state_n = CALC;
      CALC: if (last_c) state_n = CONV;
      CONV: state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Ripple of STEP chained full adders on the low operand bits
  always_comb begin
    logic c;
    c       = carry_q;
    sbits_c = '0;
    for (int unsigned i = 0; i < STEP; i++) begin
      sbits_c[i] = opa_q[i] ^ opb_q[i] ^ c;
      c          = (opa_q[i] & opb_q[i]) | (c & (opa_q[i] ^ opb_q[i]));
    end
    carry_c = c;
  end

  // Back to true form; the sum is sign-extended across the padding
  assign mag_c = sum_q[SW-1] ? -sum_q : sum_q;

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      cnt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
    end else begin
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
      if (accept_c) begin
        opa_q   <= to_tc(a[WIDTH-1], a[WIDTH-2:0]);
        opb_q   <= to_tc(b[WIDTH-1] ^ op_sub, b[WIDTH-2:0]);
        sum_q   <= '0;
        carry_q <= 1'b0;
        cnt_q   <= '0;
      end else if (state == CALC) begin
        opa_q   <= opa_q >> STEP;
        opb_q   <= opb_q >> STEP;
        sum_q   <= {sbits_c, sum_q[SW-1:STEP]};
        carry_q <= carry_c;
        cnt_q   <= cnt_q + CW'(1);
      end
      if (state == CONV) begin
        // A zero sum is never negative, so no -0 can come out
        result <= {sum_q[SW-1], mag_c[WIDTH-2:0]};
        ovf    <= |mag_c[SW-1:WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_sm_addsub_serial.sv
// Scoreboard bench for sm_addsub_serial: driver pushes model results, monitor pops on output.
module tb_sm_addsub_serial;
  localparam int unsigned W = 32;
`ifdef SM_ADDSUB_TWOBIT_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 34;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         op_sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         ovf;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   hold_ready = 1'b0;
  bit   bp_en = 1'b0;
  bit   seen = 1'b0;

  sm_addsub_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain signed integer arithmetic on the true-form values
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
    longint vx, vy, r, m;
    logic [63:0] mu;
    vx = x[W-1] ? -longint'(x[W-2:0]) : longint'(x[W-2:0]);
    vy = y[W-1] ? -longint'(y[W-2:0]) : longint'(y[W-2:0]);
    r  = sub ? vx - vy : vx + vy;
    m  = (r < 0) ? -r : r;
    mu = 64'(m);
    return {(m >= (64'sd1 <<< (W - 1))), (r < 0), mu[W-2:0]};
  endfunction

  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic sub);
    exp_t e;
    logic [W:0] m;
    int t = 0;
    while (!in_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    m = model(xa, xb, sub);
    e.ovf = m[W];
    e.res = m[W-1:0];
    e.acc = cyc + 1;
    q.push_back(e);
    a = xa; b = xb; op_sub = sub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom(); b = $urandom(); op_sub = 1'($urandom());
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || !in_ready) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  // Monitor: decides out_ready for the coming edge and scores handshakes
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !seen) begin
      seen = 1'b1;
      if (q.size() == 0) chk("spurious_valid", 64'd1, 64'd0);
      else               chk("latency", 64'(cyc - q[0].acc), 64'(LAT));
    end
    out_ready = hold_ready ? 1'b0 : (bp_en ? ($urandom_range(0, 3) != 0) : 1'b1);
    if (out_valid && out_ready && q.size() != 0) begin
      e = q.pop_front();
      chk("result", 64'(result), 64'(e.res));
      chk("ovf", 64'(ovf), 64'(e.ovf));
      seen = 1'b0;
    end
  end

  initial begin
    logic [W:0] m;
    int t;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);

    issue(32'h0000_0005, 32'h0000_0003, 1'b1);
    issue(32'h0000_0003, 32'h0000_0005, 1'b1);
    issue(32'h8000_0000, 32'h0000_0000, 1'b0);
    issue(32'h8000_0007, 32'h8000_0007, 1'b1);
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(32'h8000_0005, 32'h0000_0003, 1'b0);
    drain();

    // Back-pressure: DONE held for 5 cycles
    hold_ready = 1'b1;
    m = model(32'h1234_5678, 32'h8000_1111, 1'b0);
    issue(32'h1234_5678, 32'h8000_1111, 1'b0);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_result", 64'({ovf, result}), 64'(m));
      @(negedge clk);
    end
    hold_ready = 1'b0;
    t = 0;
    while (out_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("post_hs_in_ready", 64'(in_ready), 64'd1);
    chk("post_hs_out_valid", 64'(out_valid), 64'd0);

    // Abort in the middle of CALC
    issue(32'h0000_0100, 32'h0000_0023, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    issue(32'h8000_0064, 32'h0000_0032, 1'b1);
    drain();

    // Random operands with random back-pressure
    bp_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 3))
        0: begin ra[W-2:0] = 31'($urandom_range(0, 15)); rb[W-2:0] = 31'($urandom_range(0, 15)); end
        1: begin ra[W-2:0] = '1; end
        2: begin rb[W-2:0] = ra[W-2:0]; end
        default: ;
      endcase
      issue(ra, rb, 1'($urandom()));
    end
    drain();
    bp_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
